execute_dispatch: RTL and testbench
===================================

EXECUTE_DISPATCH -- requirements
Module: execute_dispatch

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL be a power of two in 16..64.
REQ-002 Parameter IMM_W, default 16, immediate width; SHALL satisfy 6+log2(DATA_W) <= IMM_W <= DATA_W.
REQ-003 Parameter DEPTH, default 4, dispatch queue entries; SHALL be a power of two >= 2.
REQ-004 Derived SHAMT_W = log2(DATA_W); CNT_W = log2(DEPTH)+1.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 flush  in  1  synchronous queue clear, active-high.
REQ-008 in_valid  in  1  decode offers an instruction.
REQ-009 in_ready  out  1  queue can accept.
REQ-010 src1, src2  in  DATA_W each  register operands.
REQ-011 imm  in  IMM_W  immediate field.
REQ-012 mem_data_read_in  in  DATA_W  load data.
REQ-013 control_in  in  7  [6:4] operation, [3] imm/mem select, [2:0] opselect.
REQ-014 out_valid  out  1  head entry presented to ALU/shifter/memory.
REQ-015 out_ready  in  1  downstream consumes head.
REQ-016 aluin1_out, aluin2_out, mem_data_write_out  out  DATA_W each  head operands.
REQ-017 shift_number  out  SHAMT_W  head shift amount.
REQ-018 operation_out, opselect_out  out  3 each  head control fields.
REQ-019 enable_arith, enable_shift, mem_data_wr_en  out  1 each  head unit strobes.
REQ-020 occupancy  out  CNT_W  entries held (0..DEPTH).
REQ-021 issued_count  out  16  saturating count of dispatched instructions.

Function
REQ-022 Opselect encodings: SHIFT_REG 000, ARITH_LOGIC 001, MEM_WRITE 100, MEM_READ 101; others = NOP class.
REQ-023 Push when in_valid && in_ready; pop when out_valid && out_ready; in_ready = (occupancy < DEPTH) regardless of same-cycle pop.
REQ-024 Decode at push; entry stores aluin1 = src1, mem_data_write_out = src2, operation = control_in[6:4], opselect = control_in[2:0].
REQ-025 imm sign-extended to DATA_W before use.
REQ-026 aluin2: ARITH_LOGIC -> bit3 ? imm_ext : src2; MEM_READ -> bit3 ? mem_data_read_in : 0; all others -> 0.
REQ-027 shift_number: SHIFT_REG -> imm[2] ? src2[SHAMT_W-1:0] : imm[6 +: SHAMT_W]; all others -> 0.
REQ-028 enable_arith stored 1 for ARITH_LOGIC, or MEM_READ with bit3=1; else 0.
REQ-029 enable_shift stored 1 for SHIFT_REG only; mem_data_wr_en stored 1 for MEM_WRITE with bit3=1 only.
REQ-030 Head outputs reflect queue head combinationally from storage; enable_arith, enable_shift, mem_data_wr_en SHALL be 0 whenever out_valid=0; data outputs hold last head value when empty.
REQ-031 Latency: instruction pushed in cycle N visible at head in cycle N+1 if queue empty at N.
REQ-032 Order strictly FIFO; read/write pointers wrap modulo DEPTH.
REQ-033 Simultaneous push and pop when 0 < occupancy < DEPTH: occupancy unchanged, both take effect.
REQ-034 Pop while out_valid=0 and push while in_ready=0 SHALL be ignored, no state change.
REQ-035 issued_count increments on each pop; saturates at 16'hFFFF.
REQ-036 flush: occupancy and pointers -> 0 next cycle, same-cycle push and pop discarded and not counted; issued_count retained.

Reset
REQ-037 reset SHALL dominate flush and all handshakes; next cycle: occupancy 0, out_valid 0, in_ready 1, issued_count 0, all data/control outputs 0.
REQ-038 reset mid-operation SHALL discard queued entries; no strobe asserted in the cycle after reset.

Verification
REQ-039 Push ARITH_LOGIC ctrl=7'b010_1_001, imm=16'hFFFE, src1=5 -> head aluin1=5, aluin2=32'hFFFFFFFE, enable_arith=1, operation=3'b010.
REQ-040 Push SHIFT_REG, imm[2]=0, imm[10:6]=5'd9; then imm[2]=1, src2=32'h23 -> shift_number 9 then 3, enable_shift=1 each.
REQ-041 out_ready=0, push 5 instructions with DEPTH=4 -> in_ready=0 after 4th, 5th not accepted, occupancy=4; release -> 4 pops in push order.
REQ-042 occupancy=2, push+pop same cycle -> occupancy stays 2, issued_count +1.
REQ-043 MEM_WRITE bit3=1, src2=32'hA5A5A5A5 -> mem_data_wr_en=1 with mem_data_write_out=32'hA5A5A5A5 only while out_valid; MEM_READ bit3=0 -> aluin2=0, enable_arith=0.
REQ-044 Queue holding 3, assert flush then reset -> out_valid=0 next cycle; issued_count kept after flush, 0 after reset.

Source files
------------

// File: rtl/execute_dispatch.sv
// execute_dispatch: decodes issued instructions into ALU/shifter/memory
// operand bundles and queues them in a small FIFO ahead of the units.
module execute_dispatch #(
  parameter int DATA_W = 32,
  parameter int IMM_W = 16,
  parameter int DEPTH = 4,
  localparam int SHAMT_W = $clog2(DATA_W),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  src1,
  input  logic [DATA_W-1:0]  src2,
  input  logic [IMM_W-1:0]   imm,
  input  logic [DATA_W-1:0]  mem_data_read_in,
  input  logic [6:0]         control_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  aluin1_out,
  output logic [DATA_W-1:0]  aluin2_out,
  output logic [DATA_W-1:0]  mem_data_write_out,
  output logic [SHAMT_W-1:0] shift_number,
  output logic [2:0]         operation_out,
  output logic [2:0]         opselect_out,
  output logic               enable_arith,
  output logic               enable_shift,
  output logic               mem_data_wr_en,
  output logic [CNT_W-1:0]   occupancy,
  output logic [15:0]        issued_count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] OP_SHIFT = 3'b000;
  localparam logic [2:0] OP_ARITH = 3'b001;
  localparam logic [2:0] OP_MWR   = 3'b100;
  localparam logic [2:0] OP_MRD   = 3'b101;

  typedef struct packed {
    logic [DATA_W-1:0]  a1;
    logic [DATA_W-1:0]  a2;
    logic [DATA_W-1:0]  wd;
    logic [SHAMT_W-1:0] sh;
    logic [2:0]         op;
    logic [2:0]         os;
    logic               ea;
    logic               es;
    logic               ew;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             last_q;
  entry_t             in_e;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        issued_q;
  logic [DATA_W-1:0]  imm_ext;
  logic               push;
  logic               pop;
  logic               sel;
  logic [2:0]         opsel;

  assign in_ready  = count < CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign sel       = control_in[3];
  assign opsel     = control_in[2:0];
  assign imm_ext   = {{(DATA_W-IMM_W+1){imm[IMM_W-1]}},
                      imm[IMM_W-2:0]};

  // Decode the offered instruction into a queue entry
  always_comb begin
    in_e    = '0;
    in_e.a1 = src1;
    in_e.wd = src2;
    in_e.op = control_in[6:4];
    in_e.os = opsel;
    unique case (1'b1)
      opsel == OP_ARITH: begin
        in_e.a2 = sel ? imm_ext : src2;
        in_e.ea = 1'b1;
      end
      opsel == OP_MRD: begin
        in_e.a2 = sel ? mem_data_read_in : '0;
        in_e.ea = sel;
      end
      opsel == OP_SHIFT: begin
        in_e.sh = imm[2] ? src2[SHAMT_W-1:0]
                         : imm[6 +: SHAMT_W];
        in_e.es = 1'b1;
      end
      opsel == OP_MWR: begin
        in_e.ew = sel;
      end
      default: ;
    endcase
  end

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) begin
      mem[wr_ptr] <= in_e;
    end
  end

  // Pointers, occupancy, issue counter and last-popped hold
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      issued_q <= '0;
      last_q   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
        if (issued_q != 16'hFFFF) begin
          issued_q <= issued_q + 16'd1;
        end
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Present the head, or the last popped entry when empty
  always_comb begin
    head = out_valid ? mem[rd_ptr] : last_q;
  end

  assign aluin1_out         = head.a1;
  assign aluin2_out         = head.a2;
  assign mem_data_write_out = head.wd;
  assign shift_number       = head.sh;
  assign operation_out      = head.op;
  assign opselect_out       = head.os;
  assign enable_arith       = head.ea && out_valid;
  assign enable_shift       = head.es && out_valid;
  assign mem_data_wr_en     = head.ew && out_valid;
  assign occupancy          = count;
  assign issued_count       = issued_q;

endmodule

// File: tb/tb_execute_dispatch.sv
// tb_execute_dispatch: random and directed stimulus against
// a queue-based reference model of the dispatch stage.
module tb_execute_dispatch;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src1, src2, mem_data_read_in;
  logic [15:0] imm;
  logic [6:0]  control_in;
  logic [31:0] aluin1_out, aluin2_out, mem_data_write_out;
  logic [4:0]  shift_number;
  logic [2:0]  operation_out, opselect_out;
  logic        enable_arith, enable_shift, mem_data_wr_en;
  logic [2:0]  occupancy;
  logic [15:0] issued_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a1, a2, wd;
    logic [4:0]  sh;
    logic [2:0]  op, os;
    logic        ea, es, ew;
  } ent_t;

  ent_t        q[$];
  ent_t        last;
  logic [15:0] issued;
  logic [15:0] saved;

  execute_dispatch dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .imm(imm),
    .mem_data_read_in(mem_data_read_in),
    .control_in(control_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluin1_out(aluin1_out), .aluin2_out(aluin2_out),
    .mem_data_write_out(mem_data_write_out),
    .shift_number(shift_number),
    .operation_out(operation_out),
    .opselect_out(opselect_out),
    .enable_arith(enable_arith),
    .enable_shift(enable_shift),
    .mem_data_wr_en(mem_data_wr_en),
    .occupancy(occupancy),
    .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t dec(input logic [6:0] c,
                               input logic [31:0] s1, s2,
                               input logic [15:0] im,
                               input logic [31:0] md);
    ent_t e;
    int unsigned immx;
    int unsigned code;
    bit b3;
    code = c % 8;
    b3   = (c / 8) % 2;
    immx = (im >= 16'h8000) ? 32'(im) - 32'h10000 : 32'(im);
    e.a1 = s1;
    e.wd = s2;
    e.op = 3'(c / 16);
    e.os = 3'(code);
    e.a2 = 0;
    e.sh = 0;
    e.ea = (code == 1) || (code == 5 && b3);
    e.es = (code == 0);
    e.ew = (code == 4) && b3;
    if (code == 1) e.a2 = b3 ? immx : s2;
    if (code == 5) e.a2 = b3 ? md : 0;
    if (code == 0) e.sh = 5'(((im / 4) % 2 == 1) ? s2 % 32
                                                : (im / 64) % 32);
    return e;
  endfunction

  task automatic check_all();
    ent_t h;
    bit   v;
    v = q.size() > 0;
    h = v ? q[0] : last;
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, q.size() < 4);
    chk("occupancy", occupancy, q.size());
    chk("issued", issued_count, issued);
    chk("aluin1", aluin1_out, h.a1);
    chk("aluin2", aluin2_out, h.a2);
    chk("wdata", mem_data_write_out, h.wd);
    chk("shamt", shift_number, h.sh);
    chk("operation", operation_out, h.op);
    chk("opselect", opselect_out, h.os);
    chk("en_arith", enable_arith, v && h.ea);
    chk("en_shift", enable_shift, v && h.es);
    chk("wr_en", mem_data_wr_en, v && h.ew);
  endtask

  task automatic tick();
    bit   psh, pp;
    ent_t e;
    psh = in_valid && q.size() < 4;
    pp  = out_ready && q.size() > 0;
    e   = dec(control_in, src1, src2, imm, mem_data_read_in);
    @(posedge clock);
    if (reset) begin
      q.delete();
      last = '{default: 0};
      issued = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pp) begin
        last = q.pop_front();
        if (issued != 16'hFFFF) issued++;
      end
      if (psh) q.push_back(e);
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic push1(input logic [6:0] c, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [15:0] im);
    control_in = c;
    src1 = s1;
    src2 = s2;
    imm = im;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    src1 = 0; src2 = 0; imm = 0; mem_data_read_in = 0;
    control_in = 0;
    last = '{default: 0};
    issued = 0;
    @(negedge clock);
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_aluin2", aluin2_out, 0);
    reset = 0;
    tick();

    push1(7'b010_1_001, 32'd5, 32'd77, 16'hFFFE);
    chk("d_arith_a1", aluin1_out, 32'd5);
    chk("d_arith_a2", aluin2_out, 32'hFFFFFFFE);
    chk("d_arith_en", enable_arith, 1);
    chk("d_arith_op", operation_out, 3'b010);
    out_ready = 1;
    tick();
    out_ready = 0;

    push1(7'b000_0_000, 32'd1, 32'd0, 16'h0240);
    push1(7'b000_0_000, 32'd1, 32'h23, 16'h0004);
    chk("d_shift1", shift_number, 5'd9);
    chk("d_shift1_en", enable_shift, 1);
    out_ready = 1;
    tick();
    chk("d_shift2", shift_number, 5'd3);
    chk("d_shift2_en", enable_shift, 1);
    tick();
    out_ready = 0;

    for (int i = 0; i < 5; i++) begin
      push1(7'b000_0_001, 32'(i + 100), 32'(i), 16'h0);
      chk("d_full_ready", in_ready, i < 3);
    end
    chk("d_full_occ", occupancy, 3'd4);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("d_order", aluin1_out, 32'(i + 100));
      tick();
    end
    chk("d_drained", out_valid, 0);
    out_ready = 0;

    push1(7'b000_0_001, 32'd1, 32'd1, 16'h0);
    push1(7'b000_0_001, 32'd2, 32'd2, 16'h0);
    saved = issued_count;
    out_ready = 1;
    push1(7'b000_0_001, 32'd3, 32'd3, 16'h0);
    chk("d_pp_occ", occupancy, 3'd2);
    chk("d_pp_issued", issued_count, saved + 16'd1);
    tick();
    tick();
    out_ready = 0;

    push1(7'b000_1_100, 32'd0, 32'hA5A5A5A5, 16'h0);
    chk("d_mwr_en", mem_data_wr_en, 1);
    chk("d_mwr_data", mem_data_write_out, 32'hA5A5A5A5);
    out_ready = 1;
    tick();
    chk("d_mwr_idle", mem_data_wr_en, 0);
    out_ready = 0;
    mem_data_read_in = 32'h1234_5678;
    push1(7'b000_0_101, 32'd0, 32'd0, 16'h0);
    chk("d_mrd_a2", aluin2_out, 0);
    chk("d_mrd_en", enable_arith, 0);
    out_ready = 1;
    tick();
    out_ready = 0;

    for (int i = 0; i < 3; i++)
      push1(7'b000_0_001, 32'(i), 32'(i), 16'h0);
    saved = issued_count;
    flush = 1;
    tick();
    flush = 0;
    chk("d_flush_valid", out_valid, 0);
    chk("d_flush_issued", issued_count, saved);
    for (int i = 0; i < 3; i++)
      push1(7'b000_0_001, 32'(i), 32'(i), 16'h0);
    reset = 1;
    tick();
    reset = 0;
    chk("d_reset_valid", out_valid, 0);
    chk("d_reset_issued", issued_count, 0);

    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 99) < 2;
      reset = $urandom_range(0, 199) == 0;
      src1 = $urandom;
      src2 = $urandom;
      imm = 16'($urandom);
      mem_data_read_in = $urandom;
      control_in = 7'($urandom);
      tick();
    end
    reset = 0;
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
